// File: rtl/flush_ctrl.sv
// Pipeline flush/stall controller: redirects fetch on taken branches and traps,
// stalls on load-use hazards, and holds a redirect pending until fetch accepts it.
module flush_ctrl #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned BR_STAGE   = 2,
  parameter int unsigned TRAP_STAGE = 3,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  TakenBranch,
  input  logic [XLEN-1:0]       BranchTarget,
  input  logic                  Trap,
  input  logic [XLEN-1:0]       TrapVector,
  input  logic                  LoadUseHazard,
  input  logic                  RedirectReady,
  output logic                  RedirectValid,
  output logic [XLEN-1:0]       RedirectPC,
  output logic [NUM_STAGES-1:0] Flush,
  output logic [NUM_STAGES-1:0] Stall,
  output logic                  Busy,
  output logic [CNT_W-1:0]      FlushCount
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state, next_state;
  logic [XLEN-1:0] latched_pc, next_pc;
  logic            span_trap, next_span_trap;
  logic            accept;

  function automatic logic [NUM_STAGES-1:0] span_mask(input logic use_trap);
    logic [NUM_STAGES-1:0] m;
    int unsigned lim;
    lim = use_trap ? TRAP_STAGE : BR_STAGE;
    for (int unsigned j = 0; j < NUM_STAGES; j++) m[j] = (j < lim);
    return m;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      latched_pc <= '0;
      span_trap  <= 1'b0;
      FlushCount <= '0;
    end else begin
      state      <= next_state;
      latched_pc <= next_pc;
      span_trap  <= next_span_trap;
      if (accept && FlushCount != '1) FlushCount <= FlushCount + 1'b1;
    end
  end

  always_comb begin
    next_state     = state;
    next_pc        = latched_pc;
    next_span_trap = span_trap;
    accept         = 1'b0;
    RedirectValid  = 1'b0;
    RedirectPC     = '0;
    Flush          = '0;
    Stall          = '0;
    Busy           = 1'b0;
    unique case (state)
      IDLE: begin
        if (Trap || TakenBranch) begin
          RedirectValid = 1'b1;
          RedirectPC    = Trap ? TrapVector : BranchTarget;
          Flush         = span_mask(Trap);
          if (RedirectReady) begin
            accept = 1'b1;
          end else begin
            next_state     = WAIT;
            next_pc        = RedirectPC;
            next_span_trap = Trap;
          end
        end else if (LoadUseHazard) begin
          Stall[0] = 1'b1;
          Flush[1] = 1'b1;
        end
      end
      WAIT: begin
        // A trap arriving while waiting supersedes the pending redirect but is
        // counted together with it as a single event.
        RedirectValid  = 1'b1;
        Busy           = 1'b1;
        RedirectPC     = Trap ? TrapVector : latched_pc;
        next_pc        = RedirectPC;
        next_span_trap = span_trap | Trap;
        Flush          = span_mask(next_span_trap);
        if (RedirectReady) begin
          accept     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (rst) begin
      RedirectValid = 1'b0;
      RedirectPC    = '0;
      Flush         = '0;
      Stall         = '0;
      Busy          = 1'b0;
    end
  end

endmodule
